// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m - two-master / one-slave Wishbone classic arbiter.
//
// Shares a single slave (wb_ram) between master 0 (picorv32_wb core) and
// master 1 (DMA / debug loader). Grants are registered, issued round robin
// on ties, held for as long as the granted master keeps cyc high, and always
// separated by one idle cycle.
//
// Ports:
//   wb_clk_i, wb_rst_i         clock, asynchronous active-high reset
//   m0_* / m1_*                master-side Wishbone buses (adr, dat, sel,
//                              we, cyc, stb in; dat, ack, err out)
//   s_*                        slave-side Wishbone bus
//   gnt_o                      one-hot current grant {m1,m0}, 2'b00 when idle
//
// Build option:
//   WB_ARB_TIMEOUT_EN          enables the ack watchdog; after TIMEOUT cycles
//                              of an unacknowledged strobe the granted master
//                              gets a one-cycle err and loses the grant.
module wb_arbiter_2m #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    output logic [1:0]      gnt_o
);

    if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_timeout_range
        $error("wb_arbiter_2m: TIMEOUT must be within 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   last_r;        // index of the master served most recently
    logic   last_next_s;
    logic   timeout_s;     // watchdog expiry for the current grant

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    logic [15:0] wd_cnt_r;
    logic        stb_wait_s;

    // Granted master is strobing and the slave has not answered this cycle
    always_comb begin
        stb_wait_s = 1'b0;
        case (state_r)
            ST_GNT0: stb_wait_s = m0_stb_i & ~s_ack_i;
            ST_GNT1: stb_wait_s = m1_stb_i & ~s_ack_i;
            default: stb_wait_s = 1'b0;
        endcase
    end

    assign timeout_s = (state_r != ST_IDLE) && (wd_cnt_r == TIMEOUT_C);

    // Watchdog counter; held at zero while idle so every grant starts fresh
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wd_cnt_r <= 16'd0;
        end else if ((state_r == ST_IDLE) || s_ack_i || timeout_s) begin
            wd_cnt_r <= 16'd0;
        end else if (stb_wait_s) begin
            wd_cnt_r <= wd_cnt_r + 16'd1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Grant state and round-robin pointer registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r <= ST_IDLE;
            last_r  <= 1'b1;   // m0 wins the first tie after reset
        end else begin
            state_r <= state_next_s;
            last_r  <= last_next_s;
        end
    end

    // Next grant: arbitrate only from IDLE, release on cyc drop or timeout
    always_comb begin
        state_next_s = state_r;
        last_next_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next_s = last_r ? ST_GNT0 : ST_GNT1;
                end else if (m0_cyc_i) begin
                    state_next_s = ST_GNT0;
                end else if (m1_cyc_i) begin
                    state_next_s = ST_GNT1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GNT0: begin
                if (!m0_cyc_i || timeout_s) begin
                    state_next_s = ST_IDLE;
                    last_next_s  = 1'b0;
                end else begin
                    state_next_s = ST_GNT0;
                end
            end
            ST_GNT1: begin
                if (!m1_cyc_i || timeout_s) begin
                    state_next_s = ST_IDLE;
                    last_next_s  = 1'b1;
                end else begin
                    state_next_s = ST_GNT1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                last_next_s  = last_r;
            end
        endcase
    end

    // Slave-side mux and master-side return path, all driven from the grant
    always_comb begin
        gnt_o   = 2'b00;
        s_adr_o = {AW{1'b0}};
        s_dat_o = {DW{1'b0}};
        s_sel_o = {(DW/8){1'b0}};
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        case (state_r)
            ST_GNT0: begin
                gnt_o   = 2'b01;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
                s_we_o  = m0_we_i;
                s_cyc_o = m0_cyc_i & ~timeout_s;
                s_stb_o = m0_stb_i & ~timeout_s;
            end
            ST_GNT1: begin
                gnt_o   = 2'b10;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
                s_we_o  = m1_we_i;
                s_cyc_o = m1_cyc_i & ~timeout_s;
                s_stb_o = m1_stb_i & ~timeout_s;
            end
            default: begin
                gnt_o   = 2'b00;
            end
        endcase
        // An ack that arrives while idle has no owner and is dropped here
        m0_ack_o = s_ack_i & gnt_o[0];
        m1_ack_o = s_ack_i & gnt_o[1];
        m0_err_o = timeout_s & gnt_o[0];
        m1_err_o = timeout_s & gnt_o[1];
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
    end

endmodule
